// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types, sizes and helpers for the iterative multiply/divide unit
package muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

  // Replicate bit 31 over the upper half (W-variant results and operands).
  function automatic word_t sext32(input word_t x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  function automatic logic is_div_op(input muldiv_op_t o);
    return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t o);
    return o inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - one radix-2 shift-add / restoring shift-subtract step on the 128-bit accumulator
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  word_t             opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_diff;
  logic            div_ge;

  // Multiply: {hi,lo} with the multiplier in lo; add the multiplicand into hi when lo[0]
  // is set, then shift the whole accumulator right, keeping the carry as the new MSB.
  // Divide: {rem,quo} with the dividend in quo; shift left, trial-subtract the divisor
  // from the 65-bit shifted remainder and restore when it goes negative.
  always_comb begin
    acc_out  = '0;
    mul_sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_diff = {1'b0, acc_in[2*XLEN-1:XLEN-1]} - {2'b00, opnd};
    div_ge   = ~div_diff[XLEN+1];
    if (is_div) begin
      acc_out[2*XLEN-1:XLEN] = div_ge ? div_diff[XLEN-1:0] : acc_in[2*XLEN-2:XLEN-1];
      acc_out[XLEN-1:0]      = {acc_in[XLEN-2:0], div_ge};
    end else begin
      acc_out = {mul_sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV64M multiply/divide sequencer; MULDIV_EARLY_OUT_EN enables trivial-case early out
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  muldiv_op_t op,
  input  logic       word,
  input  word_t      srca,
  input  word_t      srcb,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output word_t      result
);

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  word_t             opnd_q, opnd_d;
  word_t             result_q, result_d;
  muldiv_op_t        op_q, op_d;
  logic              word_q, word_d;
  logic              neg_q, neg_d;

  // Operand decode at accept time.
  logic              in_div, in_rem, a_signed, b_signed, a_neg, b_neg, b_zero, neg_init;
  word_t             a_val, b_val, a_mag, b_mag, opnd_init;
  logic [2*XLEN-1:0] acc_init;
  logic [CNT_W-1:0]  cnt_init;

  // Result fix-up after the last iteration.
  logic [2*XLEN-1:0] prod, prod_s;
  word_t             quo, rem, res_raw, res_fin;

  muldiv_core u_core (
    .is_div  (is_div_op(op_q)),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (acc_step)
  );

  // Widen/sign operands, take magnitudes and seed the accumulator for the selected op.
  always_comb begin
    in_div   = is_div_op(op);
    in_rem   = is_rem_op(op);
    a_signed = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_val    = word ? (a_signed ? sext32(srca) : {32'h0, srca[31:0]}) : srca;
    b_val    = word ? (b_signed ? sext32(srcb) : {32'h0, srcb[31:0]}) : srcb;
    a_neg    = a_signed & a_val[XLEN-1];
    b_neg    = b_signed & b_val[XLEN-1];
    a_mag    = a_neg ? -a_val : a_val;
    b_mag    = b_neg ? -b_val : b_val;
    b_zero   = (b_val == '0);
    cnt_init = word ? CNT_W'(32) : CNT_W'(XLEN);
    if (in_div) begin
      // W dividends start in the upper half of quo so 32 shifts bring them all through.
      acc_init  = word ? {{XLEN{1'b0}}, a_mag[31:0], 32'h0} : {{XLEN{1'b0}}, a_mag};
      opnd_init = b_mag;
      // Divide-by-zero keeps the all-ones quotient unsigned-looking regardless of dividend sign.
      neg_init  = in_rem ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
    end else begin
      acc_init  = {{XLEN{1'b0}}, b_mag};
      opnd_init = a_mag;
      neg_init  = a_neg ^ b_neg;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic  in_ovf, early;
  word_t early_raw, early_res;

  // Trivial cases whose answer is known at accept: div by zero, signed overflow, zero operand.
  always_comb begin
    in_ovf = (op inside {OP_DIV, OP_REM}) && (b_val == '1) &&
             (a_val == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    early  = in_ovf || (a_val == '0) || b_zero;
    if (in_div && b_zero) begin
      early_raw = in_rem ? a_val : '1;
    end else if (in_ovf) begin
      early_raw = in_rem ? '0 : a_val;
    end else begin
      early_raw = '0;
    end
    early_res = word ? sext32(early_raw) : early_raw;
  end
`endif

  // Turn the final accumulator into the architectural result: pick half, restore sign, W-extend.
  always_comb begin
    prod    = word_q ? {{XLEN{1'b0}}, acc_step[XLEN+31:32]} : acc_step;
    prod_s  = neg_q ? -prod : prod;
    quo     = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem     = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       res_raw = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_raw = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_raw = quo;
      default:                      res_raw = rem;
    endcase
    res_fin = word_q ? sext32(res_raw) : res_raw;
  end

  // Next-state logic: accept in IDLE, iterate in CALC, hold in DONE; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          state_d = CALC;
          cnt_d   = cnt_init;
          acc_d   = acc_init;
          opnd_d  = opnd_init;
          op_d    = op;
          word_d  = word;
          neg_d   = neg_init;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = early_res;
          end
`endif
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = res_fin;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      op_q     <= OP_MUL;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule
